wave_burst_monitor: RTL and testbench

WAVE_BURST_MONITOR -- requirements
Module: wave_burst_monitor

---
 rtl/wave_burst_monitor.sv | 207 ++++++++++++++++++++
 tb/tb_wave_burst_monitor.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/wave_burst_monitor.sv
// -----------------------------------------------------------------------------
// wave_burst_monitor
//
// Watches a DDS output stream and measures each burst of valid samples.
// A burst is a run of consecutive cycles with wave_in_valid=1. For every
// burst the block reports:
//   - the number of valid samples,
//   - the number of upward midscale crossings (with arming hysteresis),
//   - the index distance between the first and the last crossing,
//   - the largest and smallest sample,
//   - a flag that is set if any counter saturated.
// The results are registered on the cycle valid falls. res_valid pulses for
// one cycle after that. The res_* ports then hold until the next pulse.
//
// Ports
//   clk            in   single clock, rising edge
//   rst            in   synchronous, active-high reset
//   wave_in_valid  in   sample strobe; high = sample belongs to the burst
//   wave_in        in   DATA_WIDTH offset-binary sample (midscale = 2^(W-1))
//   res_valid      out  one-cycle pulse; result ports just updated
//   res_len        out  valid samples in the last burst
//   res_xcnt       out  upward midscale crossings in the last burst
//   res_span       out  index of last crossing minus index of first (0 if <2)
//   res_max        out  largest sample of the last burst
//   res_min        out  smallest sample of the last burst
//   res_ovf        out  a counter saturated during the last burst
//   busy           out  high while a burst is being measured
// -----------------------------------------------------------------------------
module wave_burst_monitor #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 24,
    parameter int XCNT_WIDTH = 8,
    parameter int HYST       = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wave_in_valid,
    input  logic [DATA_WIDTH-1:0] wave_in,
    output logic                  res_valid,
    output logic [CNT_WIDTH-1:0]  res_len,
    output logic [XCNT_WIDTH-1:0] res_xcnt,
    output logic [CNT_WIDTH-1:0]  res_span,
    output logic [DATA_WIDTH-1:0] res_max,
    output logic [DATA_WIDTH-1:0] res_min,
    output logic                  res_ovf,
    output logic                  busy
);

    localparam logic [DATA_WIDTH-1:0] MID       = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] ARM_LEVEL = MID - DATA_WIDTH'(HYST);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;
    localparam logic [XCNT_WIDTH-1:0] XCNT_MAX  = '1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Control strobes decoded from state and valid.
    logic start_burst;
    logic update_burst;
    logic end_burst;

    // Burst accumulators.
    logic [CNT_WIDTH-1:0]  idx_q;
    logic [CNT_WIDTH-1:0]  len_q;
    logic [XCNT_WIDTH-1:0] xcnt_q;
    logic [CNT_WIDTH-1:0]  first_idx_q;
    logic [CNT_WIDTH-1:0]  last_idx_q;
    logic                  have_first_q;
    logic                  have_second_q;
    logic                  armed_q;
    logic [DATA_WIDTH-1:0] max_q;
    logic [DATA_WIDTH-1:0] min_q;
    logic                  ovf_q;

    // Saturating next values and crossing detection.
    logic                  idx_sat;
    logic                  len_sat;
    logic                  xcnt_sat;
    logic [CNT_WIDTH-1:0]  idx_next;
    logic [CNT_WIDTH-1:0]  len_next;
    logic [XCNT_WIDTH-1:0] xcnt_next;
    logic                  crossing;
    logic                  below_arm;

    assign idx_sat   = (idx_q == CNT_MAX);
    assign len_sat   = (len_q == CNT_MAX);
    assign xcnt_sat  = (xcnt_q == XCNT_MAX);
    assign idx_next  = idx_sat  ? idx_q  : idx_q + 1'b1;
    assign len_next  = len_sat  ? len_q  : len_q + 1'b1;
    assign xcnt_next = xcnt_sat ? xcnt_q : xcnt_q + 1'b1;

    // A crossing needs a prior dip below MID-HYST. Small wiggles around
    // midscale therefore do not count.
    assign crossing  = armed_q && (wave_in >= MID);
    assign below_arm = (wave_in < ARM_LEVEL);

    assign busy = (state_q == ACTIVE);

    // Next-state and strobe decode.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d      = state_q;
        start_burst  = 1'b0;
        update_burst = 1'b0;
        end_burst    = 1'b0;
        case (state_q)
            IDLE: begin
                if (wave_in_valid) begin
                    state_d     = ACTIVE;
                    start_burst = 1'b1;
                end
            end
            ACTIVE: begin
                if (wave_in_valid) begin
                    update_burst = 1'b1;
                end else begin
                    state_d   = IDLE;
                    end_burst = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register, accumulators and result registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only. All
        // registers then sample the same pre-edge values.
        if (rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            len_q         <= '0;
            xcnt_q        <= '0;
            first_idx_q   <= '0;
            last_idx_q    <= '0;
            have_first_q  <= 1'b0;
            have_second_q <= 1'b0;
            armed_q       <= 1'b0;
            max_q         <= '0;
            min_q         <= '1;
            ovf_q         <= 1'b0;
            res_valid     <= 1'b0;
            res_len       <= '0;
            res_xcnt      <= '0;
            res_span      <= '0;
            res_max       <= '0;
            res_min       <= '1;
            res_ovf       <= 1'b0;
        end else begin
            state_q   <= state_d;
            res_valid <= end_burst;

            if (start_burst) begin
                // The first sample is index 0. It is never a crossing and
                // does not arm the detector.
                idx_q         <= '0;
                len_q         <= CNT_WIDTH'(1);
                xcnt_q        <= '0;
                first_idx_q   <= '0;
                last_idx_q    <= '0;
                have_first_q  <= 1'b0;
                have_second_q <= 1'b0;
                armed_q       <= 1'b0;
                max_q         <= wave_in;
                min_q         <= wave_in;
                ovf_q         <= 1'b0;
            end

            if (update_burst) begin
                idx_q <= idx_next;
                len_q <= len_next;
                ovf_q <= ovf_q | idx_sat | len_sat | (crossing & xcnt_sat);
                if (wave_in > max_q) max_q <= wave_in;
                if (wave_in < min_q) min_q <= wave_in;

                if (crossing) begin
                    xcnt_q  <= xcnt_next;
                    armed_q <= 1'b0;
                    if (!have_first_q) begin
                        first_idx_q  <= idx_next;
                        have_first_q <= 1'b1;
                    end else begin
                        last_idx_q    <= idx_next;
                        have_second_q <= 1'b1;
                    end
                end else if (below_arm) begin
                    armed_q <= 1'b1;
                end
            end

            if (end_burst) begin
                res_len  <= len_q;
                res_xcnt <= xcnt_q;
                res_span <= have_second_q ? (last_idx_q - first_idx_q) : '0;
                res_max  <= max_q;
                res_min  <= min_q;
                res_ovf  <= ovf_q;
            end
        end
    end

endmodule

// File: tb/tb_wave_burst_monitor.sv
// -----------------------------------------------------------------------------
// Testbench for wave_burst_monitor. Two instances share one stimulus stream:
//   dut_w  default widths (CNT_WIDTH=24)
//   dut_n  narrow counters (CNT_WIDTH=4), which exercises saturation
// A per-cycle behavioural model runs for each instance as the inputs are
// driven. It pushes the expected result onto a queue whenever a burst ends.
// A negedge monitor pops the queue on every res_valid and compares.
// -----------------------------------------------------------------------------
module tb_wave_burst_monitor;

    localparam int     DW     = 16;
    localparam int     HYST   = 256;
    localparam longint MID    = 32768;
    localparam longint CMAX_W = (64'd1 << 24) - 1;
    localparam longint CMAX_N = 15;
    localparam longint XMAX   = 255;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst           = 1'b1;
    logic          wave_in_valid = 1'b0;
    logic [DW-1:0] wave_in       = '0;

    logic          res_valid_w, res_ovf_w, busy_w;
    logic [23:0]   res_len_w, res_span_w;
    logic [7:0]    res_xcnt_w;
    logic [DW-1:0] res_max_w, res_min_w;

    logic          res_valid_n, res_ovf_n, busy_n;
    logic [3:0]    res_len_n, res_span_n;
    logic [7:0]    res_xcnt_n;
    logic [DW-1:0] res_max_n, res_min_n;

    wave_burst_monitor dut_w (
        .clk(clk), .rst(rst), .wave_in_valid(wave_in_valid), .wave_in(wave_in),
        .res_valid(res_valid_w), .res_len(res_len_w), .res_xcnt(res_xcnt_w),
        .res_span(res_span_w), .res_max(res_max_w), .res_min(res_min_w),
        .res_ovf(res_ovf_w), .busy(busy_w)
    );

    wave_burst_monitor #(.CNT_WIDTH(4)) dut_n (
        .clk(clk), .rst(rst), .wave_in_valid(wave_in_valid), .wave_in(wave_in),
        .res_valid(res_valid_n), .res_len(res_len_n), .res_xcnt(res_xcnt_n),
        .res_span(res_span_n), .res_max(res_max_n), .res_min(res_min_n),
        .res_ovf(res_ovf_n), .busy(busy_n)
    );

    typedef struct {
        bit     active;
        longint idx, len, xcnt, first, last, ncross;
        bit     armed;
        longint mx, mn;
        bit     ovf;
    } mstate_t;

    typedef struct {
        longint len, xcnt, span, mx, mn;
        bit     ovf;
    } res_t;

    mstate_t ms_w, ms_n;
    res_t    q_w[$], q_n[$];
    res_t    rr_w, rr_n, last_w, last_n;
    int      n_tests = 0, n_fail = 0;
    int      pulses_w = 0, pulses_n = 0, exp_w = 0, exp_n = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle of the reference model. Returns 1 when a burst ends and
    // fills r with its expected results.
    function automatic bit mstep(inout mstate_t s, input bit v, input longint d,
                                 input longint cmax, output res_t r);
        r = '{default: 0};
        if (!v) begin
            if (s.active) begin
                r.len  = s.len;
                r.xcnt = s.xcnt;
                r.span = (s.ncross >= 2) ? s.last - s.first : 0;
                r.mx   = s.mx;
                r.mn   = s.mn;
                r.ovf  = s.ovf;
                s.active = 0;
                return 1'b1;
            end
            return 1'b0;
        end
        if (!s.active) begin
            s = '{default: 0};
            s.active = 1; s.len = 1; s.mx = d; s.mn = d;
            return 1'b0;
        end
        if (s.idx == cmax) s.ovf = 1; else s.idx++;
        if (s.len == cmax) s.ovf = 1; else s.len++;
        if (d > s.mx) s.mx = d;
        if (d < s.mn) s.mn = d;
        if (s.armed && d >= MID) begin
            if (s.xcnt == XMAX) s.ovf = 1; else s.xcnt++;
            s.armed = 0;
            s.ncross++;
            if (s.ncross == 1) s.first = s.idx; else s.last = s.idx;
        end else if (d < MID - HYST) begin
            s.armed = 1;
        end
        return 1'b0;
    endfunction

    // Drive one cycle of stimulus and advance both models. busy reflects
    // everything applied so far, so it is checked before the new inputs.
    task automatic drive(input bit r, input bit v, input logic [DW-1:0] d);
        res_t res;
        @(posedge clk);
        #1;
        check("busy_w", busy_w, ms_w.active);
        check("busy_n", busy_n, ms_n.active);
        rst = r; wave_in_valid = v; wave_in = d;
        if (r) begin
            ms_w.active = 0;
            ms_n.active = 0;
        end else begin
            if (mstep(ms_w, v, d, CMAX_W, res)) begin q_w.push_back(res); exp_w++; end
            if (mstep(ms_n, v, d, CMAX_N, res)) begin q_n.push_back(res); exp_n++; end
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_valid_w", res_valid_w, 0); check("rst_len_w", res_len_w, 0);
        check("rst_xcnt_w", res_xcnt_w, 0);   check("rst_span_w", res_span_w, 0);
        check("rst_max_w", res_max_w, 0);     check("rst_min_w", res_min_w, 16'hFFFF);
        check("rst_ovf_w", res_ovf_w, 0);     check("rst_busy_w", busy_w, 0);
        check("rst_valid_n", res_valid_n, 0); check("rst_len_n", res_len_n, 0);
        check("rst_min_n", res_min_n, 16'hFFFF); check("rst_busy_n", busy_n, 0);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (res_valid_w === 1'b1) begin
            pulses_w++;
            check("res_valid_w_expected", 64'(q_w.size() != 0), 1);
            if (q_w.size() != 0) begin
                rr_w = q_w.pop_front();
                check("len_w", res_len_w, rr_w.len);   check("xcnt_w", res_xcnt_w, rr_w.xcnt);
                check("span_w", res_span_w, rr_w.span); check("max_w", res_max_w, rr_w.mx);
                check("min_w", res_min_w, rr_w.mn);     check("ovf_w", res_ovf_w, rr_w.ovf);
                last_w = rr_w;
            end
        end
        if (res_valid_n === 1'b1) begin
            pulses_n++;
            check("res_valid_n_expected", 64'(q_n.size() != 0), 1);
            if (q_n.size() != 0) begin
                rr_n = q_n.pop_front();
                check("len_n", res_len_n, rr_n.len);   check("xcnt_n", res_xcnt_n, rr_n.xcnt);
                check("span_n", res_span_n, rr_n.span); check("max_n", res_max_n, rr_n.mx);
                check("min_n", res_min_n, rr_n.mn);     check("ovf_n", res_ovf_n, rr_n.ovf);
                last_n = rr_n;
            end
        end
    end

    initial begin
        ms_w = '{default: 0};
        ms_n = '{default: 0};

        // Reset, then idle with garbage on wave_in.
        repeat (3) drive(1'b1, 1'b0, 16'h0);
        repeat (2) drive(1'b0, 1'b0, 16'($urandom));
        @(negedge clk);
        check_reset_outputs();

        // Single-sample burst.
        drive(1'b0, 1'b1, 16'h1234);
        drive(1'b0, 1'b0, 16'($urandom));

        // 1000-sample sine, period 100, starting at midscale.
        for (int i = 0; i < 1000; i++) begin
            real ph;
            ph = 2.0 * 3.14159265358979 * real'(i) / 100.0;
            drive(1'b0, 1'b1, 16'($rtoi(30000.0 * $sin(ph) + 32768.5)));
        end
        drive(1'b0, 1'b0, 16'h0);
        repeat (2) drive(1'b0, 1'b0, 16'($urandom));

        // Oscillation inside the hysteresis band never arms.
        for (int i = 0; i < 20; i++)
            drive(1'b0, 1'b1, (i % 2 == 0) ? 16'(MID - 100) : 16'(MID + 100));
        drive(1'b0, 1'b0, 16'h0);

        // Back-to-back bursts: 1x5, 0x1, 1x7.
        repeat (5) drive(1'b0, 1'b1, 16'($urandom));
        drive(1'b0, 1'b0, 16'($urandom));
        repeat (7) drive(1'b0, 1'b1, 16'($urandom));
        drive(1'b0, 1'b0, 16'($urandom));

        // Saturation boundary on the narrow instance: 15, 16 and 20 samples.
        for (int n = 15; n <= 20; n += (n == 16) ? 4 : 1) begin
            for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 16'(i * 997));
            drive(1'b0, 1'b0, 16'h0);
        end

        // Reset at sample 50 with valid held high. The aborted burst must not
        // report. A burst starts on the first cycle after reset releases.
        for (int i = 0; i < 50; i++) drive(1'b0, 1'b1, 16'($urandom));
        repeat (2) drive(1'b1, 1'b1, 16'($urandom));
        @(negedge clk);
        check_reset_outputs();
        repeat (3) drive(1'b0, 1'b1, 16'h4000);
        drive(1'b0, 1'b0, 16'h0);

        // Drain with junk data on wave_in. Results must hold.
        repeat (6) drive(1'b0, 1'b0, 16'($urandom));
        @(negedge clk);
        check("hold_len_w", res_len_w, last_w.len);
        check("hold_max_w", res_max_w, last_w.mx);
        check("hold_len_n", res_len_n, last_n.len);
        check("queue_empty_w", q_w.size(), 0);
        check("queue_empty_n", q_n.size(), 0);
        check("pulses_w", pulses_w, exp_w);
        check("pulses_n", pulses_n, exp_n);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
